// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]   r_dig;
    logic [CW-1:0]   r_count;
    logic            r_ovf_s;
    logic            r_busy;
    logic            r_done;
    logic [BW-1:0]   r_bcd;
    logic            r_ovf;

    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_dig_next;
    logic            w_ovf_next;

    always_comb begin
        w_adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_adj[4*k +: 4] = (r_dig[4*k +: 4] >= 4'd5) ? r_dig[4*k +: 4] + 4'd3
                                                         : r_dig[4*k +: 4];
        end
    end

    // Bits shifted out of the top digit are lost from the result but flag overflow.
    assign w_dig_next = {w_adj[BW-2:0], r_shift[WIDTH-1]};
    assign w_ovf_next = r_ovf_s | w_adj[BW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_dig   <= '0;
            r_count <= '0;
            r_ovf_s <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= bin;
                        r_dig   <= '0;
                        r_count <= '0;
                        r_ovf_s <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_dig   <= w_dig_next;
                    r_shift <= r_shift << 1;
                    r_ovf_s <= w_ovf_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_bcd   <= w_dig_next;
                        r_ovf   <= w_ovf_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start83 = 1'b0;
    logic [7:0]  bin83   = '0;
    logic        busy83, done83, ovf83;
    logic [11:0] bcd83;

    logic        start82 = 1'b0;
    logic [7:0]  bin82   = '0;
    logic        busy82, done82, ovf82;
    logic [7:0]  bcd82;

    logic        start42 = 1'b0;
    logic [3:0]  bin42   = '0;
    logic        busy42, done42, ovf42;
    logic [7:0]  bcd42;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut83 (
        .clk(clk), .rst(rst), .start(start83), .bin(bin83),
        .busy(busy83), .done(done83), .bcd(bcd83), .ovf(ovf83));
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut82 (
        .clk(clk), .rst(rst), .start(start82), .bin(bin82),
        .busy(busy82), .done(done82), .bcd(bcd82), .ovf(ovf82));
    bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u_dut42 (
        .clk(clk), .rst(rst), .start(start42), .bin(bin42),
        .busy(busy42), .done(done42), .bcd(bcd42), .ovf(ovf42));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [47:0] to_bcd(input longint v, input int digits);
        logic [47:0] r = '0;
        longint x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model for the 8-bit/3-digit instance: whole-value arithmetic.
    bit          m_busy = 0, m_done = 0, m_ovf = 0;
    logic [11:0] m_bcd = '0;
    int          m_left = 0;
    int          m_val  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_bcd = '0; m_ovf = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_bcd  = to_bcd(m_val, 3)[11:0];
                    m_ovf  = (m_val >= 1000);
                end
            end else if (start83) begin
                m_busy = 1;
                m_left = 8;
                m_val  = int'(bin83);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy83", busy83, m_busy);
            chk("done83", done83, m_done);
            chk("bcd83",  bcd83,  m_bcd);
            chk("ovf83",  ovf83,  m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done83(output int lat);
        lat = 0;
        while (!done83 && lat < 40) begin
            tick();
            lat++;
        end
        if (!done83) chk("timeout83", 0, 1);
    endtask

    task automatic start_83(input logic [7:0] v);
        bin83 = v; start83 = 1'b1;
        tick();
        start83 = 1'b0;
    endtask

    task automatic conv82(input logic [7:0] v, input logic [7:0] eb, input logic eo);
        int lat;
        bin82 = v; start82 = 1'b1;
        tick();
        start82 = 1'b0;
        lat = 0;
        while (!done82 && lat < 40) begin tick(); lat++; end
        if (!done82) chk("timeout82", 0, 1);
        chk("bcd82", bcd82, eb);
        chk("ovf82", ovf82, eo);
        chk("lat82", lat, 8);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [7:0] exp42;

        tick(); tick();
        chk("rst_busy", busy83, 0);
        chk("rst_done", done83, 0);
        chk("rst_bcd",  bcd83,  0);
        chk("rst_ovf",  ovf83,  0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 255 -> 255, latency 8
        start_83(8'd255);
        wait_done83(lat);
        chk("t1_lat", lat, 8);
        chk("t1_bcd", bcd83, 12'h255);
        chk("t1_ovf", ovf83, 0);

        // back-to-back with start raised in the done cycle
        tick();
        start_83(8'd0);
        wait_done83(lat);
        chk("t2_bcd0", bcd83, 12'h000);
        start_83(8'd99);
        wait_done83(lat);
        chk("t2_lat", lat, 8);
        chk("t2_bcd99", bcd83, 12'h099);
        start_83(8'd100);
        wait_done83(lat);
        chk("t2_bcd100", bcd83, 12'h100);
        chk("t2_ovf", ovf83, 0);

        // start during busy is ignored
        tick();
        start_83(8'd37);
        tick();
        start_83(8'd200);
        wait_done83(lat);
        chk("t3_bcd", bcd83, 12'h037);
        seen = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (done83) seen = 1; end
        chk("t3_nodone", seen, 0);

        // reset mid-conversion aborts
        start_83(8'd123);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_busy", busy83, 0);
        chk("t4_bcd",  bcd83,  0);
        chk("t4_ovf",  ovf83,  0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (done83) seen = 1; end
        chk("t4_nodone", seen, 0);
        start_83(8'd42);
        wait_done83(lat);
        chk("t4_bcd42", bcd83, 12'h042);

        // randomized traffic, random resets, bin churning during busy
        for (int i = 0; i < 4000; i++) begin
            start83 = ($urandom_range(0, 3) == 0);
            bin83   = 8'($urandom);
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        start83 = 1'b0; rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // two-digit overflow cases
        conv82(8'd200, 8'h00, 1'b1);
        conv82(8'd255, 8'h55, 1'b1);
        conv82(8'd99,  8'h99, 1'b0);
        tick();
        conv82(8'd100, 8'h00, 1'b1);

        // 4-bit sweep
        for (int v = 0; v < 16; v++) begin
            bin42 = 4'(v); start42 = 1'b1;
            tick();
            start42 = 1'b0;
            lat = 0;
            while (!done42 && lat < 20) begin tick(); lat++; end
            if (!done42) chk("timeout42", 0, 1);
            exp42 = to_bcd(v, 2)[7:0];
            chk("lat42", lat, 4);
            chk("bcd42", bcd42, exp42);
            chk("ovf42", ovf42, 0);
            chk("dig42", (bcd42[3:0] <= 9) && (bcd42[7:4] <= 9), 1);
            tick();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
